// File: rtl/router_out_reader.sv
// Read-side engine for one router output port: drains the port FIFO through a 2-entry
// skid buffer, frames packets (header/payload/parity), checks parity and flushes on read timeout.
module router_out_reader #(
    parameter int TIMEOUT = 30,
    parameter int DW      = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fifo_empty,
    input  logic [DW:0]   fifo_dout,
    output logic          fifo_rd_en,
    input  logic          read_enb,
    output logic          vld_out,
    output logic [DW-1:0] data_out,
    output logic          soft_reset,
    output logic          pkt_done,
    output logic          parity_err,
    output logic          hdr_err
);

    localparam int LW = DW - 2;
    localparam int SW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_PARITY
    } state_e;

    state_e        state_q, state_d;
    logic [DW:0]   buf_q [2];
    logic [DW:0]   buf_d [2];
    logic [1:0]    cnt_q, cnt_d;
    logic          inflight_q, inflight_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [DW-1:0] par_q, par_d;
    logic [SW-1:0] stall_q, stall_d;
    logic          flush_q, flush_d;
    logic          pkt_done_q, pkt_done_d;
    logic          parity_err_q, parity_err_d;
    logic          hdr_err_q, hdr_err_d;

    logic [DW:0]   head;
    logic          have_head;
    logic          drop;
    logic          xfer;
    logic          pop;
    logic          push;
    logic          stall;
    logic          timeout;
    logic [1:0]    occ;

    // A non-header byte at the head while idle is discarded without ever being presented.
    assign head      = buf_q[0];
    assign have_head = (cnt_q != 2'd0);
    assign drop      = have_head && (state_q == S_IDLE) && !head[DW];
    assign vld_out   = have_head && !drop;
    assign xfer      = vld_out && read_enb;
    assign pop       = xfer || drop;
    assign push      = inflight_q;
    assign stall     = vld_out && !read_enb;
    assign timeout   = stall && (stall_q == SW'(TIMEOUT - 1));
    assign occ       = cnt_q + {1'b0, inflight_q};

    // Reads are gated by reset so no byte is pulled out of the FIFO and then lost.
    assign fifo_rd_en = !reset && !fifo_empty && !flush_q &&
                        ((occ < 2'd2) || ((occ == 2'd2) && xfer));

    assign data_out   = head[DW-1:0];
    assign soft_reset = flush_q;
    assign pkt_done   = pkt_done_q;
    assign parity_err = parity_err_q;
    assign hdr_err    = hdr_err_q;

    always_comb begin
        // NOTE: every next-state variable gets a default first, so no path can infer a latch.
        buf_d        = buf_q;
        cnt_d        = cnt_q - {1'b0, pop} + {1'b0, push};
        inflight_d   = fifo_rd_en;
        state_d      = state_q;
        rem_d        = rem_q;
        par_d        = par_q;
        stall_d      = stall ? SW'(stall_q + 1'b1) : '0;
        flush_d      = 1'b0;
        pkt_done_d   = 1'b0;
        parity_err_d = 1'b0;
        hdr_err_d    = drop;

        if (pop) begin
            buf_d[0] = buf_q[1];
        end
        if (push) begin
            if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop)) begin
                buf_d[0] = fifo_dout;
            end else begin
                buf_d[1] = fifo_dout;
            end
        end

        if (xfer) begin
            unique case (state_q)
                S_IDLE: begin
                    rem_d   = head[DW-1:2];
                    par_d   = head[DW-1:0];
                    state_d = (head[DW-1:2] == '0) ? S_PARITY : S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    par_d = par_q ^ head[DW-1:0];
                    rem_d = rem_q - 1'b1;
                    if (rem_q == LW'(1)) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    pkt_done_d   = 1'b1;
                    parity_err_d = (head[DW-1:0] != par_q);
                    state_d      = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Timeout abandons the buffered bytes and the read in flight; the FIFO clears itself.
        if (timeout) begin
            flush_d    = 1'b1;
            cnt_d      = 2'd0;
            inflight_d = 1'b0;
            state_d    = S_IDLE;
            stall_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            // NOTE: the two skid entries are reset because the head entry drives data_out directly.
            buf_q[0]     <= '0;
            buf_q[1]     <= '0;
            cnt_q        <= 2'd0;
            inflight_q   <= 1'b0;
            rem_q        <= '0;
            par_q        <= '0;
            stall_q      <= '0;
            flush_q      <= 1'b0;
            pkt_done_q   <= 1'b0;
            parity_err_q <= 1'b0;
            hdr_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            inflight_q   <= inflight_d;
            rem_q        <= rem_d;
            par_q        <= par_d;
            stall_q      <= stall_d;
            flush_q      <= flush_d;
            pkt_done_q   <= pkt_done_d;
            parity_err_q <= parity_err_d;
            hdr_err_q    <= hdr_err_d;
        end
    end

endmodule
